// File: rtl/division_sign_restore.sv
// Divider post-stage: serially negates the raw two's-complement quotient and remainder
// into sign + unsigned magnitude, one bit per clock, LSB first.
//
// state   | meaning
// IDLE    | waiting for restore_sel; last result held
// CONVERT | both lanes shifting, WIDTH edges
// DONE    | result valid; waits for restore_sel to drop
module division_sign_restore #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] quotient_raw,
  input  logic [WIDTH-1:0] remainder_raw,
  input  logic             restore_sel,
  output logic [WIDTH-1:0] quotient_mag,
  output logic [WIDTH-1:0] remainder_mag,
  output logic             quotient_neg,
  output logic             remainder_neg,
  output logic             restore_busy,
  output logic             restore_finish
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_sh_q, q_sh_d, r_sh_q, r_sh_d;
  logic             q_sgn_q, q_sgn_d, r_sgn_q, r_sgn_d;
  logic             q_seen_q, q_seen_d, r_seen_q, r_seen_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_mag_q, q_mag_d, r_mag_q, r_mag_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic             busy_q, busy_d, finish_q, finish_d;

  // Two's-complement negation: pass bits through the first 1, invert every bit after it.
  logic             q_out, r_out;
  logic [WIDTH-1:0] q_sh_nxt, r_sh_nxt;

  assign q_out    = (q_sgn_q & q_seen_q) ? ~q_sh_q[0] : q_sh_q[0];
  assign r_out    = (r_sgn_q & r_seen_q) ? ~r_sh_q[0] : r_sh_q[0];
  assign q_sh_nxt = {q_out, q_sh_q[WIDTH-1:1]};
  assign r_sh_nxt = {r_out, r_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    q_sh_d   = q_sh_q;
    r_sh_d   = r_sh_q;
    q_sgn_d  = q_sgn_q;
    r_sgn_d  = r_sgn_q;
    q_seen_d = q_seen_q;
    r_seen_d = r_seen_q;
    cnt_d    = cnt_q;
    q_mag_d  = q_mag_q;
    r_mag_d  = r_mag_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    busy_d   = busy_q;
    finish_d = finish_q;
    case (state_q)
      IDLE: begin
        if (restore_sel) begin
          q_sh_d   = quotient_raw;
          r_sh_d   = remainder_raw;
          q_sgn_d  = quotient_raw[WIDTH-1];
          r_sgn_d  = remainder_raw[WIDTH-1];
          q_seen_d = 1'b0;
          r_seen_d = 1'b0;
          cnt_d    = '0;
          finish_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = CONVERT;
        end
      end
      CONVERT: begin
        q_sh_d   = q_sh_nxt;
        r_sh_d   = r_sh_nxt;
        q_seen_d = q_seen_q | q_sh_q[0];
        r_seen_d = r_seen_q | r_sh_q[0];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          q_mag_d  = q_sh_nxt;
          r_mag_d  = r_sh_nxt;
          q_neg_d  = q_sgn_q;
          r_neg_d  = r_sgn_q;
          finish_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        // restore_sel must drop for an edge before the next capture.
        if (!restore_sel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      q_sh_q   <= '0;
      r_sh_q   <= '0;
      q_sgn_q  <= 1'b0;
      r_sgn_q  <= 1'b0;
      q_seen_q <= 1'b0;
      r_seen_q <= 1'b0;
      cnt_q    <= '0;
      q_mag_q  <= '0;
      r_mag_q  <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_sh_q   <= q_sh_d;
      r_sh_q   <= r_sh_d;
      q_sgn_q  <= q_sgn_d;
      r_sgn_q  <= r_sgn_d;
      q_seen_q <= q_seen_d;
      r_seen_q <= r_seen_d;
      cnt_q    <= cnt_d;
      q_mag_q  <= q_mag_d;
      r_mag_q  <= r_mag_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  assign quotient_mag   = q_mag_q;
  assign remainder_mag  = r_mag_q;
  assign quotient_neg   = q_neg_q;
  assign remainder_neg  = r_neg_q;
  assign restore_busy   = busy_q;
  assign restore_finish = finish_q;

endmodule

// File: tb/tb_division_sign_restore.sv
// Directed bench for division_sign_restore (WIDTH=4): hand-computed magnitudes and signs,
// fixed-latency checks, sticky finish, no-retrigger and mid-conversion reset.
module tb_division_sign_restore;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] quotient_raw, remainder_raw;
  logic       restore_sel;
  logic [3:0] quotient_mag, remainder_mag;
  logic       quotient_neg, remainder_neg, restore_busy, restore_finish;

  int errors = 0;
  int checks = 0;

  division_sign_restore #(.WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .quotient_raw  (quotient_raw),
    .remainder_raw (remainder_raw),
    .restore_sel   (restore_sel),
    .quotient_mag  (quotient_mag),
    .remainder_mag (remainder_mag),
    .quotient_neg  (quotient_neg),
    .remainder_neg (remainder_neg),
    .restore_busy  (restore_busy),
    .restore_finish(restore_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] qm, input logic qn,
                         input logic [3:0] rm, input logic rn, input logic fin);
    chk({tag, " q_mag"}, {4'h0, quotient_mag}, {4'h0, qm});
    chk({tag, " q_neg"}, {7'h0, quotient_neg}, {7'h0, qn});
    chk({tag, " r_mag"}, {4'h0, remainder_mag}, {4'h0, rm});
    chk({tag, " r_neg"}, {7'h0, remainder_neg}, {7'h0, rn});
    chk({tag, " finish"}, {7'h0, restore_finish}, {7'h0, fin});
  endtask

  initial begin
    rst = 1'b1; restore_sel = 1'b0; quotient_raw = 4'h0; remainder_raw = 4'h0;
    step(); step();
    chk_out("reset", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("reset busy", {7'h0, restore_busy}, 8'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk_out("idle", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);

    // -3 / -1; raw inputs scrambled after capture must not matter
    quotient_raw = 4'b1101; remainder_raw = 4'b1111; restore_sel = 1'b1;
    step();
    restore_sel = 1'b0; quotient_raw = 4'b0110; remainder_raw = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      chk("t1 busy", {7'h0, restore_busy}, 8'h1);
      chk_out("t1 hold", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
      step();
    end
    chk("t1 busy last", {7'h0, restore_busy}, 8'h1);
    step();
    chk_out("t1 done", 4'b0011, 1'b1, 4'b0001, 1'b1, 1'b1);
    chk("t1 busy off", {7'h0, restore_busy}, 8'h0);
    step();
    chk_out("t1 sticky", 4'b0011, 1'b1, 4'b0001, 1'b1, 1'b1);

    // positive and zero
    quotient_raw = 4'b0101; remainder_raw = 4'b0000; restore_sel = 1'b1;
    step();
    restore_sel = 1'b0;
    chk_out("t2 capture", 4'b0011, 1'b1, 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk_out("t2 done", 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b1);
    step();

    // most-negative and max positive; restore_sel held high through DONE
    quotient_raw = 4'b1000; remainder_raw = 4'b0111; restore_sel = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk_out("t3 done", 4'b1000, 1'b1, 4'b0111, 1'b0, 1'b1);
    quotient_raw = 4'b0011; remainder_raw = 4'b1100;
    for (int i = 0; i < 5; i++) step();
    chk_out("t3 no retrig", 4'b1000, 1'b1, 4'b0111, 1'b0, 1'b1);
    chk("t3 busy", {7'h0, restore_busy}, 8'h0);

    restore_sel = 1'b0;
    step();
    quotient_raw = 4'b1110; remainder_raw = 4'b0010; restore_sel = 1'b1;
    step();
    chk_out("t4 capture", 4'b1000, 1'b1, 4'b0111, 1'b0, 1'b0);
    chk("t4 busy", {7'h0, restore_busy}, 8'h1);
    for (int i = 0; i < 4; i++) step();
    chk_out("t4 done", 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b1);
    restore_sel = 1'b0;
    step();

    // reset on the second CONVERT cycle; restore_sel high during reset
    quotient_raw = 4'b0110; remainder_raw = 4'b1001; restore_sel = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    chk_out("t5 reset", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("t5 busy", {7'h0, restore_busy}, 8'h0);
    quotient_raw = 4'b1011; remainder_raw = 4'b1010;
    step();
    chk_out("t5 in reset", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    restore_sel = 1'b0;
    chk("t5 busy after cap", {7'h0, restore_busy}, 8'h1);
    for (int i = 0; i < 3; i++) step();
    chk_out("t5 early", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    chk_out("t5 done", 4'b0101, 1'b1, 4'b0110, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/division_sign_restore.md
Name: division_sign_restore

Overview:
- Post-processing stage for the signed divider; the counterpart of the operand two's-complement pre-stage.
- Takes the raw two's-complement quotient and remainder from the divider core and converts each to sign + magnitude for the display/encoding path.
- Negation is done bit-serially, LSB first, over WIDTH cycles: copy bits up to and including the first 1, invert every bit after it.
- Uses the same sel/finish handshake as the rest of the calculator pipeline.

Parameters:
- WIDTH, 4, bit width of quotient/remainder words; the MSB is the sign bit of the raw inputs.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- quotient_raw  input  WIDTH  two's-complement quotient from the divider
- remainder_raw  input  WIDTH  two's-complement remainder from the divider
- restore_sel  input  1  start request, level; sampled only in IDLE
- quotient_mag  output  WIDTH  unsigned magnitude of the quotient (registered)
- remainder_mag  output  WIDTH  unsigned magnitude of the remainder (registered)
- quotient_neg  output  1  quotient sign, 1 = negative
- remainder_neg  output  1  remainder sign, 1 = negative
- restore_busy  output  1  high while in CONVERT
- restore_finish  output  1  results valid; sticky until the next capture

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; internal shift registers, bit counter and seen_one flags cleared.
- States: IDLE, CONVERT, DONE.
- IDLE, on a rising edge with restore_sel=1 (capture edge):
  - q_sh<=quotient_raw; r_sh<=remainder_raw.
  - q_sgn<=quotient_raw[WIDTH-1]; r_sgn<=remainder_raw[WIDTH-1].
  - q_seen<=0; r_seen<=0; cnt<=0.
  - restore_finish<=0; restore_busy<=1; go to CONVERT.
- CONVERT, every edge; quotient and remainder lanes run in parallel and independently:
  - b = sh[0]; out = sgn ? (seen ? ~b : b) : b.
  - seen <= seen | b.
  - sh <= {out, sh[WIDTH-1:1]}.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1:
    - write final shifted values to quotient_mag/remainder_mag.
    - quotient_neg<=q_sgn; remainder_neg<=r_sgn.
    - restore_finish<=1; restore_busy<=0; go to DONE.
- Latency is fixed: restore_finish and the outputs are valid exactly WIDTH edges after the capture edge (4 for WIDTH=4), regardless of sign.
- restore_sel is ignored during CONVERT. Raw input changes after the capture edge have no effect.
- DONE: outputs hold. When restore_sel=0 on an edge, go to IDLE with restore_finish still 1.
  - Holding restore_sel high never retriggers; it must drop for at least one edge before a new capture.
- Outputs change only on the final CONVERT edge or on reset. Between capture and completion they keep the previous result, with restore_finish=0.
- Boundary: the most-negative input (1000 for WIDTH=4) gives magnitude 1000 (8 unsigned) with neg=1. No overflow flag; the magnitude is read as unsigned.
- Zero input: magnitude 0, neg=0.
- Reset mid-CONVERT: aborts immediately; outputs 0; next capture starts cleanly.
- Reset and restore_sel high together: reset wins; capture happens on the first edge after rst deasserts if restore_sel is still high.

Test Plan:
- Reset: assert rst -> all outputs 0, state IDLE. Release; restore_sel=0 for 10 cycles -> outputs stay 0, restore_finish=0.
- quotient_raw=1101 (-3), remainder_raw=1111 (-1), pulse restore_sel -> exactly 4 edges after capture:
  - quotient_mag=0011, quotient_neg=1, remainder_mag=0001, remainder_neg=1, restore_finish=1.
  - restore_busy high for those 4 cycles.
- quotient_raw=0101, remainder_raw=0000 -> after 4 edges: 0101/0 and 0000/0, finish=1.
- quotient_raw=1000, remainder_raw=0111 -> quotient_mag=1000, neg=1; remainder_mag=0111, neg=0.
- restore_sel held high through DONE for 5 cycles -> no restart; outputs stable.
  - Drop restore_sel for 1 cycle, raise it with new inputs 1110 -> finish clears on the capture edge; 4 edges later quotient_mag=0010, neg=1.
- Start a conversion, assert rst on the 2nd CONVERT cycle -> outputs 0 immediately, finish=0.
  - Restart with 1011 -> after 4 edges quotient_mag=0101, neg=1.
